mod_74x08_quad_and2: RTL and testbench

Quad 2-input AND gate block modelled on the 74x08 logic IC, for the 74xx discrete-logic library. Four independent AND gates drive a combinational output vector. A clocked shadow register and per-gate edge flags let synchronous logic sample the gate outputs. Parameter `SPLIT` selects one of two structural implementations with identical external behaviour, matching the library's `MOD_74x08_4` and `MOD_74x08_4_SPLIT` cells.

---
 rtl/mod_74x08_quad_and2_if.sv | 28 ++
 rtl/mod_74x08_quad_and2.sv | 64 ++++++
 tb/tb_mod_74x08_quad_and2.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mod_74x08_quad_and2_if.sv
// Signal bundle for one 74x08 quad AND block.
// The master drives the gate inputs; the slave returns gate and edge outputs.
interface mod_74x08_quad_and2_if;
  logic [0:3] a;
  logic [0:3] b;
  logic [0:3] y;
  logic [0:3] y_q;
  logic [0:3] rise;
  logic [0:3] fall;

  modport master (
    output a,
    output b,
    input  y,
    input  y_q,
    input  rise,
    input  fall
  );

  modport slave (
    input  a,
    input  b,
    output y,
    output y_q,
    output rise,
    output fall
  );
endinterface

// File: rtl/mod_74x08_quad_and2.sv
// 74x08 quad 2-input AND with a clocked shadow register
// and per-gate rise/fall pulses.
module mod_74x08_and1 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule

module mod_74x08_quad_and2 #(
  parameter int SPLIT = 0
) (
  input  logic [0:3] A,
  input  logic [0:3] B,
  output logic [0:3] Y,
  input  logic       CLK,
  input  logic       RST_N,
  output logic [0:3] Y_Q,
  output logic [0:3] RISE,
  output logic [0:3] FALL
);
  logic [0:3] y_w;
  logic [0:3] y_q_q, y_q_d;
  logic [0:3] rise_q, rise_d;
  logic [0:3] fall_q, fall_d;

  if (SPLIT != 0) begin : g_split
    for (genvar g = 0; g < 4; g++) begin : g_gate
      mod_74x08_and1 u_and (
        .a_i (A[g]),
        .b_i (B[g]),
        .y_o (y_w[g])
      );
    end
  end else begin : g_vec
    assign y_w = A & B;
  end

  assign Y = y_w;

  // Edge flags compare against the pre-edge shadow value.
  always_comb begin
    y_q_d  = y_w;
    rise_d = y_w & ~y_q_q;
    fall_d = ~y_w & y_q_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      y_q_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      y_q_q  <= y_q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign Y_Q  = y_q_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
endmodule

// File: tb/tb_mod_74x08_quad_and2.sv
// Scoreboard bench: SPLIT=0 and SPLIT=1 side by side
// against a per-gate truth-table reference model.
module tb_mod_74x08_quad_and2;
  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:3] a = '0;
  logic [0:3] b = '0;

  mod_74x08_quad_and2_if if0 ();
  mod_74x08_quad_and2_if if1 ();

  assign if0.a = a;
  assign if0.b = b;
  assign if1.a = a;
  assign if1.b = b;

  mod_74x08_quad_and2 #(.SPLIT(0)) u_vec (
    .A     (if0.a),
    .B     (if0.b),
    .Y     (if0.y),
    .CLK   (clk),
    .RST_N (rst_n),
    .Y_Q   (if0.y_q),
    .RISE  (if0.rise),
    .FALL  (if0.fall)
  );

  mod_74x08_quad_and2 #(.SPLIT(1)) u_split (
    .A     (if1.a),
    .B     (if1.b),
    .Y     (if1.y),
    .CLK   (clk),
    .RST_N (rst_n),
    .Y_Q   (if1.y_q),
    .RISE  (if1.rise),
    .FALL  (if1.fall)
  );

  always begin
    #10;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    bit         clocked;
    logic [0:3] y;
    logic [0:3] yq;
    logic [0:3] rise;
    logic [0:3] fall;
    string      tag;
  } exp_t;

  exp_t sb[$];
  event smp;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [0:3] prev = '0;

  function automatic logic [0:3] ref_and(
    input logic [0:3] x,
    input logic [0:3] z
  );
    logic [0:3] r;
    for (int n = 0; n < 4; n++) begin
      if (x[n] === 1'b0 || z[n] === 1'b0)
        r[n] = 1'b0;
      else if (x[n] === 1'b1 && z[n] === 1'b1)
        r[n] = 1'b1;
      else
        r[n] = 1'bx;
    end
    return r;
  endfunction

  task automatic chk(
    input string      name,
    input logic [0:3] act,
    input logic [0:3] exp
  );
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %b want %b t=%0t",
               name, act, exp, $time);
    else
      n_pass++;
  endtask

  always @(posedge clk) begin
    #1;
    -> smp;
  end

  initial begin
    exp_t e;
    forever begin
      @(smp);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, " Y0"}, if0.y, e.y);
        chk({e.tag, " Y1"}, if1.y, e.y);
        if (e.clocked) begin
          chk({e.tag, " YQ0"}, if0.y_q, e.yq);
          chk({e.tag, " YQ1"}, if1.y_q, e.yq);
          chk({e.tag, " RISE0"}, if0.rise, e.rise);
          chk({e.tag, " RISE1"}, if1.rise, e.rise);
          chk({e.tag, " FALL0"}, if0.fall, e.fall);
          chk({e.tag, " FALL1"}, if1.fall, e.fall);
          chk({e.tag, " EXCL0"},
              if0.rise & if0.fall, 4'b0000);
        end
      end
    end
  end

  task automatic comb(
    input string      tag,
    input logic [0:3] ai,
    input logic [0:3] bi
  );
    exp_t e;
    a = ai;
    b = bi;
    e.clocked = 1'b0;
    e.y = ref_and(ai, bi);
    e.yq = '0;
    e.rise = '0;
    e.fall = '0;
    e.tag = tag;
    sb.push_back(e);
    #20;
    -> smp;
    #1;
  endtask

  // Applied at a falling edge; checked after the next rising edge.
  task automatic cyc(
    input string      tag,
    input logic [0:3] ai,
    input logic [0:3] bi,
    input logic       rn
  );
    exp_t e;
    @(negedge clk);
    a = ai;
    b = bi;
    rst_n = rn;
    e.clocked = 1'b1;
    e.y = ref_and(ai, bi);
    e.tag = tag;
    if (!rn) begin
      e.yq = '0;
      e.rise = '0;
      e.fall = '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        e.rise[n] = (e.y[n] == 1'b1) && (prev[n] == 1'b0);
        e.fall[n] = (e.y[n] == 1'b0) && (prev[n] == 1'b1);
      end
      e.yq = e.y;
    end
    prev = e.yq;
    sb.push_back(e);
  endtask

  initial begin
    logic [0:3] xa;
    logic [0:3] xb;
    comb("all_hi", 4'b1111, 4'b1111);
    comb("a_lo", 4'b0000, 4'b1111);
    comb("b_lo", 4'b1111, 4'b0000);
    comb("both_lo", 4'b0000, 4'b0000);
    comb("order1", 4'b1010, 4'b1100);
    comb("order2", 4'b0111, 4'b0011);
    xa = 4'b0x1z;
    xb = 4'bx01z;
    comb("xz", xa, xb);

    clk_run = 1'b1;
    cyc("rst1", 4'b1111, 4'b1111, 1'b0);
    cyc("rst2", 4'b1010, 4'b0110, 1'b0);
    cyc("rel", 4'b1111, 4'b1111, 1'b1);
    cyc("hold", 4'b1111, 4'b1111, 1'b1);
    cyc("fall", 4'b1111, 4'b0101, 1'b1);
    cyc("fhold", 4'b1111, 4'b0101, 1'b1);
    cyc("midrst", 4'b0000, 4'b1111, 1'b0);

    cyc("eq_rel", 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = i[7:0];
      cyc("eq", v[7:4], v[3:0], 1'b1);
    end

    for (int i = 0; i < 150; i++) begin
      logic [0:3] ra;
      logic [0:3] rb;
      logic       rr;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 15) != 0);
      cyc("rnd", ra, rb, rr);
    end

    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0)
      $display("FAIL drain: got %0d left want 0", sb.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
